wb_master_arbiter: RTL and testbench

- Shares one Wishbone slave bus between two masters, e.g. the CPU core and memory_tester, in front of the slave arbiter/display/memory.
- Grants bus ownership with fair round-robin and holds each grant for a whole Wishbone cycle (cyc).
- Multiplexes the owner's signals to the shared bus and routes ack/data back to the owner.
- Contains a watchdog that terminates strobes the slave never acks with an error pulse.

---
 rtl/wb_master_arbiter_if.sv | 35 +++
 rtl/wb_master_arbiter.sv | 111 +++++++++++
 tb/tb_wb_master_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_master_arbiter_if.sv
// Bus bundle between two Wishbone masters, the arbiter and the shared slave.
// The arbiter takes the slave modport; master drivers and slave models take the master modport.
interface wb_master_arbiter_if #(
  parameter int ADR_W = 16,
  parameter int DAT_W = 16
);
  logic [1:0]         mCyc_i;
  logic [1:0]         mStb_i;
  logic [1:0]         mWe_i;
  logic [3:0]         mSel_i;
  logic [2*ADR_W-1:0] mAdr_i;
  logic [2*DAT_W-1:0] mDat_i;
  logic [1:0]         mAck_o;
  logic [1:0]         mErr_o;
  logic [DAT_W-1:0]   mDat_o;
  logic [1:0]         gnt_o;
  logic               cyc_o;
  logic               stb_o;
  logic               we_o;
  logic [1:0]         sel_o;
  logic [ADR_W-1:0]   adr_o;
  logic [DAT_W-1:0]   dat_o;
  logic               ack_i;
  logic [DAT_W-1:0]   dat_i;

  modport slave (
    input  mCyc_i, mStb_i, mWe_i, mSel_i, mAdr_i, mDat_i, ack_i, dat_i,
    output mAck_o, mErr_o, mDat_o, gnt_o, cyc_o, stb_o, we_o, sel_o, adr_o, dat_o
  );

  modport master (
    output mCyc_i, mStb_i, mWe_i, mSel_i, mAdr_i, mDat_i, ack_i, dat_i,
    input  mAck_o, mErr_o, mDat_o, gnt_o, cyc_o, stb_o, we_o, sel_o, adr_o, dat_o
  );
endinterface

// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave between two masters, holding
// each grant for a full cyc and terminating unacknowledged strobes with err.
module wb_master_arbiter #(
  parameter int ADR_W   = 16,
  parameter int DAT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input logic               clk_i,
  input logic               rst_i,
  wb_master_arbiter_if.slave bus
);

  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            lastGnt_q, lastGnt_d;
  logic [WD_W-1:0] wdCnt_q, wdCnt_d;

  logic active;
  logic idx;
  logic ownCyc;
  logic ownStb;
  logic wdFire;
  logic ownAck;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      lastGnt_q <= 1'b1;
      wdCnt_q   <= '0;
    end else begin
      state_q   <= state_d;
      lastGnt_q <= lastGnt_d;
      wdCnt_q   <= wdCnt_d;
    end
  end

  // Reset also masks the return path so an interrupted cycle gets neither ack nor err.
  always_comb begin
    active = (state_q != IDLE) && !rst_i;
    idx    = (state_q == OWN1);
    ownCyc = idx ? bus.mCyc_i[1] : bus.mCyc_i[0];
    ownStb = idx ? bus.mStb_i[1] : bus.mStb_i[0];
    wdFire = (TIMEOUT > 0) && active && (wdCnt_q == WD_MAX) && !bus.ack_i;
    ownAck = active && bus.ack_i && ownStb;
  end

  always_comb begin
    state_d   = state_q;
    lastGnt_d = lastGnt_q;
    case (state_q)
      IDLE: begin
        if (bus.mCyc_i[0] && bus.mCyc_i[1]) begin
          state_d   = lastGnt_q ? OWN0 : OWN1;
          lastGnt_d = ~lastGnt_q;
        end else if (bus.mCyc_i[0]) begin
          state_d   = OWN0;
          lastGnt_d = 1'b0;
        end else if (bus.mCyc_i[1]) begin
          state_d   = OWN1;
          lastGnt_d = 1'b1;
        end
      end
      OWN0:    if (!bus.mCyc_i[0]) state_d = IDLE;
      OWN1:    if (!bus.mCyc_i[1]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Clearing on fire keeps the counter from ever passing TIMEOUT.
  always_comb begin
    if ((TIMEOUT == 0) || !active || !ownStb || bus.ack_i || wdFire) begin
      wdCnt_d = '0;
    end else begin
      wdCnt_d = wdCnt_q + 1'b1;
    end
  end

  always_comb begin
    bus.gnt_o  = 2'b00;
    bus.cyc_o  = 1'b0;
    bus.stb_o  = 1'b0;
    bus.we_o   = 1'b0;
    bus.sel_o  = 2'b00;
    bus.adr_o  = '0;
    bus.dat_o  = '0;
    bus.mAck_o = 2'b00;
    bus.mErr_o = 2'b00;
    bus.mDat_o = '0;
    if (active) begin
      bus.gnt_o  = idx ? 2'b10 : 2'b01;
      bus.cyc_o  = ownCyc;
      bus.stb_o  = ownStb && !wdFire;
      bus.we_o   = idx ? bus.mWe_i[1] : bus.mWe_i[0];
      bus.sel_o  = idx ? bus.mSel_i[3:2] : bus.mSel_i[1:0];
      bus.adr_o  = idx ? bus.mAdr_i[2*ADR_W-1:ADR_W] : bus.mAdr_i[ADR_W-1:0];
      bus.dat_o  = idx ? bus.mDat_i[2*DAT_W-1:DAT_W] : bus.mDat_i[DAT_W-1:0];
      bus.mAck_o = idx ? {ownAck, 1'b0} : {1'b0, ownAck};
      bus.mErr_o = idx ? {wdFire, 1'b0} : {1'b0, wdFire};
      bus.mDat_o = bus.dat_i;
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Randomised and directed bench for wb_master_arbiter; a behavioural model
// pushes expected outputs into a scoreboard that a negedge monitor drains.
module tb_wb_master_arbiter;
  localparam int ADR_W   = 16;
  localparam int DAT_W   = 16;
  localparam int TIMEOUT = 4;

  typedef logic [58:0] outVec_t;
  typedef struct {
    string      tag;
    outVec_t    exp;
    bit         chkLit;
    logic [1:0] gntLit;
    logic [1:0] errLit;
  } sbEntry_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  wb_master_arbiter_if #(.ADR_W(ADR_W), .DAT_W(DAT_W)) bus ();

  wb_master_arbiter #(.ADR_W(ADR_W), .DAT_W(DAT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clock),
    .rst_i(reset),
    .bus  (bus)
  );

  sbEntry_t sbQ[$];
  int checks = 0;
  int errors = 0;

  // Model state: owner index or -1 when idle, last winner, strobe cycles without ack.
  int mOwner = -1;
  int mLast  = 1;
  int mWd    = 0;

  logic [1:0]  gWe;
  logic [3:0]  gSel;
  logic [15:0] gA0, gA1, gD0, gD1, gSdat;

  task automatic applyStimulus(input logic r, input logic [1:0] cyc, input logic [1:0] stb,
                               input logic ack, input string tag, input bit chk,
                               input logic [1:0] gL, input logic [1:0] eL);
    sbEntry_t    e;
    bit          act, fire;
    int          o;
    logic [1:0]  gnt, mAck, mErr, sl;
    logic        c, s, w;
    logic [15:0] ad, dt, md;
    reset          = r;
    bus.mCyc_i     = cyc;
    bus.mStb_i     = stb;
    bus.mWe_i      = gWe;
    bus.mSel_i     = gSel;
    bus.mAdr_i     = {gA1, gA0};
    bus.mDat_i     = {gD1, gD0};
    bus.ack_i      = ack;
    bus.dat_i      = gSdat;
    act  = (mOwner >= 0) && !r;
    o    = (mOwner < 0) ? 0 : mOwner;
    fire = act && (mWd == TIMEOUT) && !ack;
    gnt = 2'b00; c = 1'b0; s = 1'b0; w = 1'b0; sl = 2'b00;
    ad = 16'h0; dt = 16'h0; mAck = 2'b00; mErr = 2'b00; md = 16'h0;
    if (act) begin
      gnt  = 2'(1 << o);
      c    = cyc[o];
      s    = stb[o] && !fire;
      w    = gWe[o];
      sl   = 2'(gSel >> (2 * o));
      ad   = (o == 1) ? gA1 : gA0;
      dt   = (o == 1) ? gD1 : gD0;
      mAck = (ack && stb[o]) ? 2'(1 << o) : 2'b00;
      mErr = fire ? 2'(1 << o) : 2'b00;
      md   = gSdat;
    end
    e.tag    = tag;
    e.exp    = {gnt, c, s, w, sl, ad, dt, mAck, mErr, md};
    e.chkLit = chk;
    e.gntLit = gL;
    e.errLit = eL;
    sbQ.push_back(e);
    @(posedge clock);
    if (r) begin
      mOwner = -1;
      mLast  = 1;
      mWd    = 0;
    end else begin
      if (!act || ack || !stb[o] || fire) mWd = 0;
      else mWd = mWd + 1;
      if (mOwner < 0) begin
        if (cyc == 2'b11) mOwner = 1 - mLast;
        else if (cyc[0]) mOwner = 0;
        else if (cyc[1]) mOwner = 1;
        if (mOwner >= 0) mLast = mOwner;
      end else if (!cyc[mOwner]) begin
        mOwner = -1;
      end
    end
    #1;
  endtask

  task automatic checkOutput(input sbEntry_t e);
    outVec_t got;
    got = {bus.gnt_o, bus.cyc_o, bus.stb_o, bus.we_o, bus.sel_o, bus.adr_o, bus.dat_o,
           bus.mAck_o, bus.mErr_o, bus.mDat_o};
    checks++;
    if (got !== e.exp) begin
      errors++;
      $display("[TB] FAIL %s outputs: got %h expected %h", e.tag, got, e.exp);
    end
    if (e.chkLit) begin
      checks++;
      if (bus.gnt_o !== e.gntLit) begin
        errors++;
        $display("[TB] FAIL %s gnt_o: got %b expected %b", e.tag, bus.gnt_o, e.gntLit);
      end
      checks++;
      if (bus.mErr_o !== e.errLit) begin
        errors++;
        $display("[TB] FAIL %s mErr_o: got %b expected %b", e.tag, bus.mErr_o, e.errLit);
      end
    end
  endtask

  always @(negedge clock) begin
    if (sbQ.size() > 0) checkOutput(sbQ.pop_front());
  end

  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 2'b00, 2'b00, 1'b0, "reset", 1'b1, 2'b00, 2'b00);
  endtask

  initial begin
    int run0, run1;
    logic c0, c1;
    reset = 1'b1;
    gWe = 2'b01; gSel = 4'b0011; gA0 = 16'h0010; gA1 = 16'h5555;
    gD0 = 16'hBEEF; gD1 = 16'h7777; gSdat = 16'hCAFE;
    bus.mCyc_i = 2'b00; bus.mStb_i = 2'b00; bus.mWe_i = 2'b00; bus.mSel_i = 4'h0;
    bus.mAdr_i = '0; bus.mDat_i = '0; bus.ack_i = 1'b0; bus.dat_i = '0;
    @(posedge clock);
    #1;
    $display("[TB] starting");

    doReset(3);
    applyStimulus(1'b0, 2'b01, 2'b01, 1'b0, "m0 req", 1'b1, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b01, 2'b01, 1'b1, "m0 ack", 1'b1, 2'b01, 2'b00);
    applyStimulus(1'b0, 2'b00, 2'b00, 1'b0, "m0 drop", 1'b1, 2'b01, 2'b00);
    applyStimulus(1'b0, 2'b00, 2'b00, 1'b0, "m0 idle", 1'b1, 2'b00, 2'b00);

    doReset(2);
    gWe = 2'b10; gSel = 4'b1001;
    applyStimulus(1'b0, 2'b11, 2'b11, 1'b0, "cont req", 1'b1, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b11, 2'b11, 1'b1, "cont own0", 1'b1, 2'b01, 2'b00);
    applyStimulus(1'b0, 2'b10, 2'b10, 1'b0, "cont m0 drop", 1'b1, 2'b01, 2'b00);
    applyStimulus(1'b0, 2'b10, 2'b10, 1'b0, "cont gap", 1'b1, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b10, 2'b10, 1'b1, "cont own1", 1'b1, 2'b10, 2'b00);
    applyStimulus(1'b0, 2'b01, 2'b01, 1'b0, "cont m1 drop", 1'b1, 2'b10, 2'b00);
    applyStimulus(1'b0, 2'b11, 2'b11, 1'b0, "cont gap2", 1'b1, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b11, 2'b11, 1'b0, "cont regrant0", 1'b1, 2'b01, 2'b00);
    applyStimulus(1'b0, 2'b00, 2'b00, 1'b0, "cont end", 1'b1, 2'b01, 2'b00);
    applyStimulus(1'b0, 2'b00, 2'b00, 1'b0, "cont idle", 1'b1, 2'b00, 2'b00);

    // Each master keeps one acked strobe per grant, then releases and re-requests.
    doReset(1);
    run0 = 0; run1 = 0;
    for (int i = 0; i < 24; i++) begin
      run0 = (mOwner == 0) ? run0 + 1 : 0;
      run1 = (mOwner == 1) ? run1 + 1 : 0;
      c0 = !(mOwner == 0 && run0 >= 2);
      c1 = !(mOwner == 1 && run1 >= 2);
      applyStimulus(1'b0, {c1, c0}, {c1, c0}, 1'b1, "fair", 1'b0, 2'b00, 2'b00);
    end

    doReset(1);
    gA0 = 16'h0040;
    applyStimulus(1'b0, 2'b01, 2'b01, 1'b0, "to req", 1'b1, 2'b00, 2'b00);
    for (int k = 1; k <= 11; k++)
      applyStimulus(1'b0, 2'b01, 2'b01, 1'b0, "timeout", 1'b1, 2'b01,
                    (k == 5 || k == 10) ? 2'b01 : 2'b00);
    doReset(1);
    applyStimulus(1'b0, 2'b01, 2'b01, 1'b0, "to ack req", 1'b1, 2'b00, 2'b00);
    for (int k = 1; k <= 7; k++)
      applyStimulus(1'b0, 2'b01, 2'b01, (k == 5), "timeout ack wins", 1'b1, 2'b01, 2'b00);

    doReset(1);
    gA0 = 16'h0002; gA1 = 16'h1234;
    applyStimulus(1'b0, 2'b01, 2'b01, 1'b0, "iso req", 1'b1, 2'b00, 2'b00);
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b0, 2'b11, 2'b11, 1'(i % 2), "isolation", 1'b1, 2'b01, 2'b00);

    doReset(1);
    applyStimulus(1'b0, 2'b10, 2'b10, 1'b0, "rm req", 1'b1, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b10, 2'b10, 1'b0, "rm own1", 1'b1, 2'b10, 2'b00);
    applyStimulus(1'b1, 2'b10, 2'b10, 1'b1, "rm reset", 1'b1, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b11, 2'b11, 1'b0, "rm after", 1'b1, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b11, 2'b11, 1'b0, "rm regrant0", 1'b1, 2'b01, 2'b00);

    for (int i = 0; i < 400; i++) begin
      gWe = 2'($urandom); gSel = 4'($urandom);
      gA0 = 16'($urandom); gA1 = 16'($urandom);
      gD0 = 16'($urandom); gD1 = 16'($urandom); gSdat = 16'($urandom);
      applyStimulus(($urandom_range(63) == 0),
                    {($urandom_range(4) != 0), ($urandom_range(4) != 0)},
                    2'($urandom), ($urandom_range(2) == 0), "random", 1'b0, 2'b00, 2'b00);
    end

    repeat (3) @(negedge clock);
    if (sbQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard drain: %0d entries left, 0 required", sbQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
